// File: rtl/pds_stream_arbiter.sv
// Round-robin packet arbiter sharing one PDS link between NUM_SRC sources.
// Grants are held for a whole packet; a stall watchdog frees a silent grant.
module pds_stream_arbiter #(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned SRC_W     = $clog2(NUM_SRC),
   parameter int unsigned STALL_MAX = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC-1:0]         in_valid,
   input  logic [NUM_SRC*DATA_W-1:0]  in_data,
   input  logic [NUM_SRC-1:0]         in_last,
   output logic [NUM_SRC-1:0]         in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_last,
   output logic [SRC_W-1:0]           out_src,
   input  logic                       out_ready,
   output logic                       out_abort,
   output logic                       busy
);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   localparam logic [7:0]       STALL_LIMIT = 8'(STALL_MAX - 1);
   localparam logic [SRC_W-1:0] LAST_SRC    = SRC_W'(NUM_SRC - 1);

   state_t            state_q, state_d;
   logic [SRC_W-1:0]  grant_q, grant_d;
   logic [SRC_W-1:0]  last_grant_q, last_grant_d;
   logic [7:0]        stall_cnt_q, stall_cnt_d;
   logic              abort_q, abort_d;

   logic [SRC_W-1:0]  pick;
   logic [SRC_W-1:0]  scan_idx;
   logic              pick_found;
   logic              g_valid;
   logic              g_last;
   logic [DATA_W-1:0] g_data;
   logic              xfer;

   // Scan starts one past the previous winner, so that winner ranks last.
   always_comb begin
      pick       = '0;
      scan_idx   = '0;
      pick_found = 1'b0;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         scan_idx = SRC_W'((32'(last_grant_q) + i) % NUM_SRC);
         if (!pick_found && in_valid[scan_idx]) begin
            pick       = scan_idx;
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_q == SRC_W'(i)) begin
            g_valid = in_valid[i];
            g_last  = in_last[i];
            g_data  = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      busy      = (state_q == ST_BUSY);
      out_valid = busy & g_valid;
      out_last  = busy & g_last;
      out_data  = busy ? g_data : '0;
      out_src   = busy ? grant_q : '0;
      out_abort = abort_q;
      xfer      = out_valid & out_ready;
      in_ready  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         in_ready[i] = busy & (grant_q == SRC_W'(i)) & out_ready;
      end
   end

   // Backpressure (valid held, ready low) leaves the stall counter untouched.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      stall_cnt_d  = stall_cnt_q;
      abort_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall_cnt_d = '0;
            if (pick_found) begin
               grant_d = pick;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (xfer) begin
               stall_cnt_d = '0;
               if (g_last) begin
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end
            end else if (!g_valid) begin
               if (stall_cnt_q >= STALL_LIMIT) begin
                  abort_d      = 1'b1;
                  last_grant_d = grant_q;
                  stall_cnt_d  = '0;
                  state_d      = ST_IDLE;
               end else if (stall_cnt_q != 8'hFF) begin
                  stall_cnt_d = stall_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_SRC;
         stall_cnt_q  <= '0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         stall_cnt_q  <= stall_cnt_d;
         abort_q      <= abort_d;
      end
   end

endmodule

// File: tb/tb_pds_stream_arbiter.sv
// Directed bench for pds_stream_arbiter: reset, round-robin, backpressure,
// watchdog abort, single-beat contention and mid-packet reset.
module tb_pds_stream_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [SW-1:0]   out_src;
   logic            out_ready;
   logic            out_abort;
   logic            busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Per-source beat stores: bit 8 = last, bits 7:0 = data.
   logic [8:0]   sbuf [N][8];
   int           sptr [N];
   int           slen [N];
   logic [N-1:0] mute;

   always #5 clk = ~clk;

   pds_stream_arbiter #(
      .NUM_SRC   (4),
      .DATA_W    (8),
      .STALL_MAX (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready),
      .out_abort (out_abort),
      .busy      (busy)
   );

   task automatic apply();
      for (int s = 0; s < N; s++) begin
         if (sptr[s] < slen[s] && !mute[s]) begin
            in_valid[s]          = 1'b1;
            in_data[s*DW +: DW]  = sbuf[s][sptr[s]][7:0];
            in_last[s]           = sbuf[s][sptr[s]][8];
         end else begin
            in_valid[s]          = 1'b0;
            in_data[s*DW +: DW]  = '0;
            in_last[s]           = 1'b0;
         end
      end
      #2;
   endtask

   task automatic advance();
      logic [N-1:0] acc;
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
         if (acc[s]) sptr[s]++;
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b1;
      mute      = '0;
      for (int s = 0; s < N; s++) begin
         sptr[s] = 0;
         slen[s] = 0;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      in_valid  = '1;
      in_data   = 32'hDEADBEEF;
      in_last   = '1;
      out_ready = 1'b1;
      #2;
      n_cmp++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_abort !== 1'b0 ||
          in_ready !== 4'b0000 || out_data !== 8'h00 || out_src !== 2'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b l=%b busy=%b abort=%b rdy=%b data=%h src=%0d, want all 0",
                  out_valid, out_last, busy, out_abort, in_ready, out_data, out_src);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%b v=%b rdy=%b, want 0 0 0000", busy, out_valid, in_ready);
      end
      @(posedge clk);
      #3;
      n_cmp++;
      if (busy !== 1'b1 || out_src !== 2'd0 || out_valid !== 1'b1 || in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL reset_first_grant: got busy=%b src=%0d v=%b rdy=%b, want 1 0 1 0001",
                  busy, out_src, out_valid, in_ready);
      end
   endtask

   task automatic test_round_robin();
      int idx;
      int p;
      int es;
      int ecyc;
      logic eb;
      logic [7:0] ed;
      do_reset();
      for (int s = 0; s < N; s++) begin
         slen[s] = (s == 0) ? 4 : 2;
         for (int j = 0; j < slen[s]; j++) begin
            sbuf[s][j] = {1'(j % 2), 8'(s * 16 + (j / 2) * 4 + (j % 2))};
         end
      end
      idx = 0;
      while (idx < 10 && cyc < 40) begin
         apply();
         if (out_valid && out_ready) begin
            p    = idx / 2;
            eb   = 1'(idx % 2);
            es   = p % 4;
            ed   = 8'(es * 16 + (p / 4) * 4 + (idx % 2));
            ecyc = 3 * p + 1 + (idx % 2);
            n_cmp++;
            if (out_src !== 2'(es) || out_data !== ed || out_last !== eb || cyc != ecyc) begin
               n_err++;
               $display("FAIL rr_beat%0d: got src=%0d data=%h last=%b cyc=%0d, want src=%0d data=%h last=%b cyc=%0d",
                        idx, out_src, out_data, out_last, cyc, es, ed, eb, ecyc);
            end
            idx++;
         end
         advance();
      end
      n_cmp++;
      if (idx != 10) begin
         n_err++;
         $display("FAIL rr_count: got %0d beats, want 10", idx);
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] rp;
      logic [7:0] ed [6];
      rp = 6'b110011;
      ed = '{8'h00, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA3};
      do_reset();
      sbuf[2][0] = {1'b0, 8'hA1};
      sbuf[2][1] = {1'b0, 8'hA2};
      sbuf[2][2] = {1'b1, 8'hA3};
      slen[2]    = 3;
      for (int c = 0; c < 7; c++) begin
         out_ready = (c >= 1 && c <= 5) ? rp[c] : 1'b1;
         apply();
         n_cmp++;
         if (c >= 1 && c <= 5) begin
            if (out_valid !== 1'b1 || out_data !== ed[c] || out_last !== (c == 5) ||
                in_ready !== {1'b0, out_ready, 2'b00} || out_abort !== 1'b0 || out_src !== 2'd2) begin
               n_err++;
               $display("FAIL bp_cycle%0d: got v=%b data=%h last=%b rdy=%b abort=%b src=%0d, want 1 %h %b %b 0 2",
                        c, out_valid, out_data, out_last, in_ready, out_abort, out_src,
                        ed[c], (c == 5), {1'b0, out_ready, 2'b00});
            end
         end else begin
            if (busy !== 1'b0 || out_abort !== 1'b0 || in_ready !== 4'b0000) begin
               n_err++;
               $display("FAIL bp_idle%0d: got busy=%b abort=%b rdy=%b, want 0 0 0000",
                        c, busy, out_abort, in_ready);
            end
         end
         advance();
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      sbuf[1][0] = {1'b0, 8'h55};
      slen[1]    = 1;
      sbuf[2][0] = {1'b1, 8'h66};
      slen[2]    = 1;
      mute       = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         if (c == 1) mute = '0;
         apply();
         n_cmp++;
         if (c == 0) begin
            if (busy !== 1'b0 || out_abort !== 1'b0) begin
               n_err++;
               $display("FAIL wd_arb: got busy=%b abort=%b, want 0 0", busy, out_abort);
            end
         end else if (c == 1) begin
            if (out_valid !== 1'b1 || out_data !== 8'h55 || out_src !== 2'd1 || in_ready !== 4'b0010) begin
               n_err++;
               $display("FAIL wd_beat: got v=%b data=%h src=%0d rdy=%b, want 1 55 1 0010",
                        out_valid, out_data, out_src, in_ready);
            end
         end else if (c <= 17) begin
            if (out_abort !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 4'b0010) begin
               n_err++;
               $display("FAIL wd_stall%0d: got abort=%b busy=%b v=%b rdy=%b, want 0 1 0 0010",
                        c, out_abort, busy, out_valid, in_ready);
            end
         end else if (c == 18) begin
            if (out_abort !== 1'b1 || busy !== 1'b0 || in_ready !== 4'b0000) begin
               n_err++;
               $display("FAIL wd_abort: got abort=%b busy=%b rdy=%b, want 1 0 0000",
                        out_abort, busy, in_ready);
            end
         end else begin
            if (out_abort !== 1'b0 || busy !== 1'b1 || out_src !== 2'd2 || out_valid !== 1'b1 ||
                out_data !== 8'h66 || out_last !== 1'b1) begin
               n_err++;
               $display("FAIL wd_next: got abort=%b busy=%b src=%0d v=%b data=%h last=%b, want 0 1 2 1 66 1",
                        out_abort, busy, out_src, out_valid, out_data, out_last);
            end
         end
         advance();
      end
   endtask

   task automatic test_single_beat();
      do_reset();
      sbuf[3][0] = {1'b1, 8'h3C};
      slen[3]    = 1;
      sbuf[0][0] = {1'b1, 8'h0C};
      slen[0]    = 1;
      mute       = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) mute = '0;
         apply();
         n_cmp++;
         case (c)
            1: if (out_src !== 2'd3 || out_valid !== 1'b1 || out_data !== 8'h3C ||
                   out_last !== 1'b1 || in_ready !== 4'b1000) begin
                  n_err++;
                  $display("FAIL sb_src3: got src=%0d v=%b data=%h last=%b rdy=%b, want 3 1 3c 1 1000",
                           out_src, out_valid, out_data, out_last, in_ready);
               end
            3: if (out_src !== 2'd0 || out_valid !== 1'b1 || out_data !== 8'h0C ||
                   out_last !== 1'b1 || in_ready !== 4'b0001) begin
                  n_err++;
                  $display("FAIL sb_src0: got src=%0d v=%b data=%h last=%b rdy=%b, want 0 1 0c 1 0001",
                           out_src, out_valid, out_data, out_last, in_ready);
               end
            default: if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin
                  n_err++;
                  $display("FAIL sb_idle%0d: got busy=%b v=%b rdy=%b, want 0 0 0000",
                           c, busy, out_valid, in_ready);
               end
         endcase
         advance();
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      sbuf[0][0] = {1'b1, 8'h01};
      slen[0]    = 1;
      for (int j = 0; j < 4; j++) sbuf[1][j] = {1'(j == 3), 8'(8'h20 + j)};
      slen[1] = 4;
      apply();
      advance();
      apply();
      n_cmp++;
      if (out_src !== 2'd0 || out_data !== 8'h01 || out_last !== 1'b1 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL mr_first: got src=%0d data=%h last=%b v=%b, want 0 01 1 1",
                  out_src, out_data, out_last, out_valid);
      end
      advance();
      apply();
      advance();
      apply();
      n_cmp++;
      if (out_src !== 2'd1 || out_data !== 8'h20 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL mr_beat1: got src=%0d data=%h v=%b, want 1 20 1", out_src, out_data, out_valid);
      end
      advance();
      rst = 1'b0;
      apply();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 4'b0000 || out_abort !== 1'b0) begin
         n_err++;
         $display("FAIL mr_reset: got v=%b busy=%b rdy=%b abort=%b, want 0 0 0000 0",
                  out_valid, busy, in_ready, out_abort);
      end
      sbuf[0][1] = {1'b1, 8'h02};
      slen[0]    = 2;
      advance();
      rst = 1'b1;
      apply();
      advance();
      apply();
      n_cmp++;
      if (out_src !== 2'd0 || out_data !== 8'h02 || out_valid !== 1'b1 || out_abort !== 1'b0) begin
         n_err++;
         $display("FAIL mr_restart: got src=%0d data=%h v=%b abort=%b, want 0 02 1 0",
                  out_src, out_data, out_valid, out_abort);
      end
      advance();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_backpressure();
      test_watchdog();
      test_single_beat();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
